// File: rtl/sensor_reader.sv
// sensor_reader
//
// Consumer end of the sensor controller handshake. When the controller raises
// i_sensor_done, the packed sensor bus is captured into a local snapshot and
// o_ack is pulsed for one cycle. The snapshot is then streamed one word per
// transfer over a valid/ready interface, word 0 (least significant slice) first.
//
// Optional feature (macro SENSOR_READER_HEADER_EN): each frame is prefixed by a
// BITWIDTH-bit frame sequence number, which starts at 0 after reset and
// increments (wrapping) on acceptance of each frame's last word.
//
// Parameters:
//   SENSORS   number of sensors; the input bus carries 2*SENSORS words
//   BITWIDTH  width of one data word
//
// Ports:
//   i_clk          clock, rising edge
//   i_rst          synchronous active-high reset
//   i_data         packed sensor words, word i at [(i+1)*BITWIDTH-1 : i*BITWIDTH]
//   i_sensor_done  i_data is valid for capture (sampled only in IDLE)
//   o_ack          one-cycle pulse confirming capture
//   o_out_data     current stream word, 0 while o_out_valid is low
//   o_out_valid    o_out_data is valid
//   i_out_ready    downstream accepts when o_out_valid & i_out_ready
//   o_out_last     final word of the frame, 0 while o_out_valid is low
//
// All outputs are registered.

module sensor_reader #(
   parameter int unsigned SENSORS  = 1,
   parameter int unsigned BITWIDTH = 32
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic [2*SENSORS*BITWIDTH-1:0] i_data,
   input  logic                          i_sensor_done,
   output logic                          o_ack,
   output logic [BITWIDTH-1:0]           o_out_data,
   output logic                          o_out_valid,
   input  logic                          i_out_ready,
   output logic                          o_out_last
);

   localparam int unsigned NWORDS = 2 * SENSORS;
`ifdef SENSOR_READER_HEADER_EN
   localparam int unsigned NFRAME = NWORDS + 1;
`else
   localparam int unsigned NFRAME = NWORDS;
`endif
   localparam int unsigned  IW       = $clog2(NFRAME + 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(NFRAME - 1);

   typedef enum logic {StIdle, StSend} state_t;

   state_t              r_state, w_state_nxt;
   logic [IW-1:0]       r_idx, w_idx_nxt;
   logic                r_ack, w_ack_nxt;
   logic                r_out_valid, w_out_valid_nxt;
   logic [BITWIDTH-1:0] r_out_data, w_out_data_nxt;
   logic                r_out_last, w_out_last_nxt;
   logic [BITWIDTH-1:0] r_snap [NWORDS];

   logic                w_capture;
   logic                w_accept;
   logic [IW-1:0]       w_idx_inc;
   logic [IW-1:0]       w_snap_sel;
   logic [BITWIDTH-1:0] w_word_inc;
   logic [BITWIDTH-1:0] w_first_word;

`ifdef SENSOR_READER_HEADER_EN
   logic [BITWIDTH-1:0] r_seq, w_seq_nxt;

   // Frame word j (j >= 1) is sensor word j-1, so the word after r_idx is snap[r_idx].
   assign w_snap_sel   = r_idx;
   assign w_first_word = r_seq;
`else
   assign w_snap_sel   = w_idx_inc;
   assign w_first_word = i_data[BITWIDTH-1:0];
`endif

   assign w_idx_inc = r_idx + IW'(1);
   assign w_accept  = r_out_valid & i_out_ready;

   // Word presented after the current one; out-of-range selects give 0 and are never used.
   always_comb begin
      w_word_inc = '0;
      for (int unsigned i = 0; i < NWORDS; i++) begin
         if (w_snap_sel == IW'(i)) begin
            w_word_inc = r_snap[i];
         end
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      w_state_nxt     = r_state;
      w_idx_nxt       = r_idx;
      w_ack_nxt       = 1'b0;
      w_out_valid_nxt = r_out_valid;
      w_out_data_nxt  = r_out_data;
      w_out_last_nxt  = r_out_last;
      w_capture       = 1'b0;
`ifdef SENSOR_READER_HEADER_EN
      w_seq_nxt       = r_seq;
`endif
      unique case (r_state)
         StIdle: begin
            w_out_valid_nxt = 1'b0;
            w_out_data_nxt  = '0;
            w_out_last_nxt  = 1'b0;
            if (i_sensor_done) begin
               w_capture       = 1'b1;
               w_state_nxt     = StSend;
               w_idx_nxt       = '0;
               w_ack_nxt       = 1'b1;
               w_out_valid_nxt = 1'b1;
               // First word comes straight from the bus (or header) on the capture edge.
               w_out_data_nxt  = w_first_word;
               // A frame always has at least two words, so word 0 is never last.
               w_out_last_nxt  = 1'b0;
            end
         end
         StSend: begin
            if (w_accept) begin
               if (r_out_last) begin
                  w_state_nxt     = StIdle;
                  w_idx_nxt       = '0;
                  w_out_valid_nxt = 1'b0;
                  w_out_data_nxt  = '0;
                  w_out_last_nxt  = 1'b0;
`ifdef SENSOR_READER_HEADER_EN
                  w_seq_nxt       = r_seq + BITWIDTH'(1);
`endif
               end else begin
                  w_idx_nxt      = w_idx_inc;
                  w_out_data_nxt = w_word_inc;
                  w_out_last_nxt = (w_idx_inc == LAST_IDX);
               end
            end
         end
         default: begin
            w_state_nxt     = StIdle;
            w_out_valid_nxt = 1'b0;
            w_out_data_nxt  = '0;
            w_out_last_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= StIdle;
         r_idx       <= '0;
         r_ack       <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
`ifdef SENSOR_READER_HEADER_EN
         r_seq       <= '0;
`endif
      end else begin
         r_state     <= w_state_nxt;
         r_idx       <= w_idx_nxt;
         r_ack       <= w_ack_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_out_data  <= w_out_data_nxt;
         r_out_last  <= w_out_last_nxt;
`ifdef SENSOR_READER_HEADER_EN
         r_seq       <= w_seq_nxt;
`endif
      end
   end

   // Snapshot is pure datapath; it is only ever read after a capture.
   always_ff @(posedge i_clk) begin
      if (w_capture) begin
         for (int unsigned i = 0; i < NWORDS; i++) begin
            r_snap[i] <= i_data[i*BITWIDTH +: BITWIDTH];
         end
      end
   end

   assign o_ack       = r_ack;
   assign o_out_valid = r_out_valid;
   assign o_out_data  = r_out_data;
   assign o_out_last  = r_out_last;

endmodule
